// File: rtl/pipelined_be_ram.sv
// pipelined_be_ram: single-port RAM with per-byte write enables and in-order tagged responses.
// Latency: READ_LATENCY cycles from the accept edge to the registered ready pulse, for reads and writes alike.
// Backpressure: none; one request per cycle when en & valid. Define RAM_PARITY_EN for per-byte parity and par_inj.
module pipelined_be_ram #(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_DEPTH    = 48,
  parameter int READ_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic                    valid,
  input  logic                    wr_rd,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic [DATA_WIDTH/8-1:0] be,
`ifdef RAM_PARITY_EN
  input  logic                    par_inj,
`endif
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    ready,
  output logic                    error,
  output logic [1:0]              err_code,
  output logic                    busy
);

  localparam int NB = DATA_WIDTH / 8;
  // Depth widened by one bit so MEM_DEPTH == 2^ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(MEM_DEPTH);

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_X     = 2'b10;
`ifdef RAM_PARITY_EN
  localparam logic [1:0] ERR_PAR   = 2'b11;
`endif

  typedef struct packed {
    logic                  vld;
    logic                  is_rd;
    logic [1:0]            code;
    logic [DATA_WIDTH-1:0] dat;
  } stage_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
`ifdef RAM_PARITY_EN
  logic [NB-1:0]         par_mem [MEM_DEPTH];
  logic                  rd_par_bad;
`endif

  logic   acc;
  logic   in_range;
  logic   din_x;
  logic   wr_ok;
  stage_t cap;
  stage_t pipe [READ_LATENCY];
  stage_t last;

  assign acc      = rstn & en & valid;
  assign in_range = ({1'b0, addr} < DEPTH_W);

  // X/Z on write data is only observable in a 4-state simulator; hardware never sees it.
`ifdef SYNTHESIS
  assign din_x = 1'b0;
`else
  assign din_x = $isunknown(din);
`endif

  assign wr_ok = acc & wr_rd & in_range & ~din_x;

  // Byte-masked array write at the accept edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= din[8*i +: 8];
`ifdef RAM_PARITY_EN
          par_mem[addr][i]    <= (^din[8*i +: 8]) ^ par_inj;
`endif
        end
      end
    end
  end

  // Build the response tag for the request presented this cycle; reads sample the array here.
  always_comb begin
    cap = '0;
`ifdef RAM_PARITY_EN
    rd_par_bad = 1'b0;
`endif
    if (acc) begin
      cap.vld   = 1'b1;
      cap.is_rd = ~wr_rd;
      if (!in_range) begin
        cap.code = ERR_RANGE;
      end else if (wr_rd) begin
        if (din_x) cap.code = ERR_X;
      end else begin
        cap.dat = mem[addr];
`ifdef RAM_PARITY_EN
        for (int i = 0; i < NB; i++) begin
          if (par_mem[addr][i] != (^mem[addr][8*i +: 8])) rd_par_bad = 1'b1;
        end
        if (rd_par_bad) cap.code = ERR_PAR;
`endif
      end
    end
  end

  // Shift every tag one stage per cycle; bubbles are all-zero entries.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < READ_LATENCY; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= cap;
      for (int k = 1; k < READ_LATENCY; k++) pipe[k] <= pipe[k-1];
    end
  end

  assign last = pipe[READ_LATENCY-1];

  // Retire the oldest stage into the registered response outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ready    <= 1'b0;
      error    <= 1'b0;
      err_code <= ERR_OK;
      dout     <= '0;
    end else begin
      ready    <= last.vld;
      error    <= last.vld & (last.code != ERR_OK);
      err_code <= last.vld ? last.code : ERR_OK;
      dout     <= (last.vld && last.is_rd) ? last.dat : '0;
    end
  end

  // Busy while any tag is in flight, including the cycle its response is presented.
  always_comb begin
    busy = ready;
    for (int k = 0; k < READ_LATENCY; k++) busy = busy | pipe[k].vld;
  end

endmodule

// File: tb/tb_pipelined_be_ram.sv
`timescale 1ns/1ps
module tb_pipelined_be_ram;
  localparam int AW = 6, DW = 32, DEPTH = 48, NB = 4, NC = 4096, NROW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn = 1'b1;
  logic          en = 1'b0, valid = 1'b0, wr_rd = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] din = '0;
  logic [NB-1:0] be = '0;
`ifdef RAM_PARITY_EN
  logic          par_inj = 1'b0;
`endif

  logic [DW-1:0] dout1, dout2, dout4;
  logic          ready1, ready2, ready4, error1, error2, error4, busy1, busy2, busy4;
  logic [1:0]    code1, code2, code4;

  pipelined_be_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .READ_LATENCY(1)) u1 (
    .clk(clk), .rstn(rstn), .en(en), .valid(valid), .wr_rd(wr_rd), .addr(addr), .din(din), .be(be),
`ifdef RAM_PARITY_EN
    .par_inj(par_inj),
`endif
    .dout(dout1), .ready(ready1), .error(error1), .err_code(code1), .busy(busy1));

  pipelined_be_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .READ_LATENCY(2)) u2 (
    .clk(clk), .rstn(rstn), .en(en), .valid(valid), .wr_rd(wr_rd), .addr(addr), .din(din), .be(be),
`ifdef RAM_PARITY_EN
    .par_inj(par_inj),
`endif
    .dout(dout2), .ready(ready2), .error(error2), .err_code(code2), .busy(busy2));

  pipelined_be_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .READ_LATENCY(4)) u4 (
    .clk(clk), .rstn(rstn), .en(en), .valid(valid), .wr_rd(wr_rd), .addr(addr), .din(din), .be(be),
`ifdef RAM_PARITY_EN
    .par_inj(par_inj),
`endif
    .dout(dout4), .ready(ready4), .error(error4), .err_code(code4), .busy(busy4));

  // Reference model: word array plus a per-cycle log of accepted requests and their expected responses.
  logic [DW-1:0] mdl_mem [DEPTH];
  logic [NB-1:0] mdl_bad [DEPTH];
  bit            h_vld [NC];
  logic [1:0]    h_code [NC];
  logic [DW-1:0] h_dat [NC];
  bit            t_vld [NC];
  logic [1:0]    t_code [NC];
  logic [DW-1:0] t_dat [NC];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          en, valid, wr;
    int          addr;
    logic [31:0] din;
    logic [3:0]  be;
    logic [1:0]  code;
    logic [31:0] dat;
  } row_t;
  row_t tbl [NROW];

  function automatic row_t mk(bit e, bit v, bit w, int a, logic [31:0] d, logic [3:0] b,
                              logic [1:0] c, logic [31:0] x);
    row_t r;
    r.en = e; r.valid = v; r.wr = w; r.addr = a; r.din = d; r.be = b; r.code = c; r.dat = x;
    return r;
  endfunction

  task automatic model_accept();
    int a;
    a = int'(addr);
    if (a >= DEPTH) begin
      h_code[cyc] = 2'b01;
    end else if (wr_rd) begin
      if ($isunknown(din)) h_code[cyc] = 2'b10;
      else begin
        for (int i = 0; i < NB; i++) begin
          if (be[i]) begin
            mdl_mem[a][8*i +: 8] = din[8*i +: 8];
`ifdef RAM_PARITY_EN
            mdl_bad[a][i] = par_inj;
`endif
          end
        end
      end
    end else begin
      h_dat[cyc] = mdl_mem[a];
      if (mdl_bad[a] != '0) h_code[cyc] = 2'b11;
    end
  endtask

  task automatic chk(string nm, int lat, logic r, logic e, logic [1:0] cd, logic b, logic [DW-1:0] d);
    bit er, eb;
    logic [1:0] ec;
    logic [DW-1:0] ed;
    int a;
    a  = cyc - lat;
    er = (a >= 0) && h_vld[a];
    ec = er ? h_code[a] : 2'b00;
    ed = er ? h_dat[a] : '0;
    eb = 1'b0;
    for (int k = cyc - lat; k <= cyc; k++) if (k >= 0 && h_vld[k]) eb = 1'b1;
    checks++;
    if ({r, e, cd, b, d} !== {er, ec != 2'b00, ec, eb, ed}) begin
      errors++;
      $display("FAIL %s cyc %0d got rdy=%b err=%b code=%b busy=%b dout=%h want rdy=%b err=%b code=%b busy=%b dout=%h",
               nm, cyc, r, e, cd, b, d, er, ec != 2'b00, ec, eb, ed);
    end
    if (er && t_vld[a]) begin
      checks++;
      if ({e, cd, d} !== {t_code[a] != 2'b00, t_code[a], t_dat[a]}) begin
        errors++;
        $display("FAIL tbl_%s cyc %0d got err=%b code=%b dout=%h want err=%b code=%b dout=%h",
                 nm, cyc, e, cd, d, t_code[a] != 2'b00, t_code[a], t_dat[a]);
      end
    end
  endtask

  task automatic check_all();
    chk("lat1", 1, ready1, error1, code1, busy1, dout1);
    chk("lat2", 2, ready2, error2, code2, busy2, dout2);
    chk("lat4", 4, ready4, error4, code4, busy4, dout4);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    h_vld[cyc]  = rstn && en && valid;
    h_code[cyc] = 2'b00;
    h_dat[cyc]  = '0;
    t_vld[cyc]  = 1'b0;
    if (h_vld[cyc]) model_accept();
    #1;
    check_all();
  endtask

  task automatic idle(int n);
    valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic req(bit w, int a, logic [DW-1:0] d, logic [NB-1:0] b);
    en = 1'b1; valid = 1'b1; wr_rd = w; addr = AW'(a); din = d; be = b;
    tick();
  endtask

  // Asynchronous reset mid-flight: everything in the pipes is dropped.
  task automatic do_reset();
    rstn = 1'b0;
    for (int k = 0; k <= cyc; k++) h_vld[k] = 1'b0;
    #1;
    check_all();
    tick();
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] xval;
    for (int i = 0; i < DEPTH; i++) begin mdl_mem[i] = '0; mdl_bad[i] = '0; end
    for (int i = 0; i < NC; i++) begin h_vld[i] = 1'b0; t_vld[i] = 1'b0; end

    tbl[0]  = mk(1, 1, 1, 5,  32'hDEADBEEF, 4'hF, 2'b00, 32'h0);
    tbl[1]  = mk(1, 1, 0, 5,  32'h0,        4'hF, 2'b00, 32'hDEADBEEF);
    tbl[2]  = mk(1, 1, 1, 0,  32'h11223344, 4'hF, 2'b00, 32'h0);
    tbl[3]  = mk(1, 1, 1, 0,  32'hAABBCCDD, 4'h5, 2'b00, 32'h0);
    tbl[4]  = mk(1, 1, 0, 0,  32'h0,        4'hF, 2'b00, 32'h11BB33DD);
    tbl[5]  = mk(1, 1, 1, 47, 32'h47474747, 4'hF, 2'b00, 32'h0);
    tbl[6]  = mk(1, 1, 1, 3,  32'h33333333, 4'hF, 2'b00, 32'h0);
    tbl[7]  = mk(1, 1, 1, 1,  32'h00000001, 4'hF, 2'b00, 32'h0);
    tbl[8]  = mk(1, 1, 0, 1,  32'h0,        4'hF, 2'b00, 32'h00000001);
    tbl[9]  = mk(1, 1, 0, 47, 32'h0,        4'hF, 2'b00, 32'h47474747);
    tbl[10] = mk(1, 1, 0, 48, 32'h0,        4'hF, 2'b01, 32'h0);
    tbl[11] = mk(1, 1, 1, 48, 32'hFFFFFFFF, 4'hF, 2'b01, 32'h0);
    tbl[12] = mk(1, 1, 1, 63, 32'hFFFFFFFF, 4'hF, 2'b01, 32'h0);
    tbl[13] = mk(1, 1, 1, 5,  32'h12345678, 4'h0, 2'b00, 32'h0);
    tbl[14] = mk(1, 1, 0, 5,  32'h0,        4'hF, 2'b00, 32'hDEADBEEF);
    tbl[15] = mk(0, 1, 1, 5,  32'h0,        4'hF, 2'b00, 32'h0);
    tbl[16] = mk(0, 1, 1, 5,  32'h0,        4'hF, 2'b00, 32'h0);
    tbl[17] = mk(0, 1, 1, 5,  32'h0,        4'hF, 2'b00, 32'h0);
    tbl[18] = mk(1, 1, 0, 5,  32'h0,        4'hF, 2'b00, 32'hDEADBEEF);
    tbl[19] = mk(1, 1, 0, 63, 32'h0,        4'hF, 2'b01, 32'h0);

    #2 rstn = 1'b0;
    idle(3);
    rstn = 1'b1;
    idle(2);

    // Directed table, applied back to back.
    for (int i = 0; i < NROW; i++) begin
      en = tbl[i].en; valid = tbl[i].valid; wr_rd = tbl[i].wr;
      addr = AW'(tbl[i].addr); din = tbl[i].din; be = tbl[i].be;
      tick();
      if (tbl[i].en && tbl[i].valid) begin
        t_vld[cyc] = 1'b1; t_code[cyc] = tbl[i].code; t_dat[cyc] = tbl[i].dat;
      end
    end
    en = 1'b1;
    idle(6);

    // Reset while a read is in flight.
    req(0, 5, '0, 4'hF);
    idle(1);
    do_reset();
    idle(6);

    // Write with unknown data bits: rejected where the simulator can represent X.
    xval = 32'hXXXX0000;
    req(1, 3, xval, 4'hF);
    din = '0;
    req(0, 3, '0, 4'hF);
    t_vld[cyc] = 1'b1;
    t_code[cyc] = 2'b00;
    t_dat[cyc] = $isunknown(xval) ? 32'h33333333 : 32'h00000000;
    idle(6);

`ifdef RAM_PARITY_EN
    par_inj = 1'b1;
    req(1, 7, 32'hCAFE0001, 4'hF);
    par_inj = 1'b0;
    req(0, 7, '0, 4'hF);
    t_vld[cyc] = 1'b1; t_code[cyc] = 2'b11; t_dat[cyc] = 32'hCAFE0001;
    req(1, 7, 32'h0, 4'hF);
    idle(6);
`endif

    // Fill every word so random reads have defined data.
    for (int a = 0; a < DEPTH; a++) req(1, a, $urandom, 4'hF);
    idle(4);

    // Random traffic against the model, with one asynchronous reset in the middle.
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      en    = ($urandom_range(0, 9) != 0);
      valid = ($urandom_range(0, 4) != 0);
      wr_rd = 1'($urandom_range(0, 1));
      addr  = AW'($urandom_range(0, 63));
      din   = $urandom;
      be    = NB'($urandom_range(0, 15));
`ifdef RAM_PARITY_EN
      par_inj = ($urandom_range(0, 7) == 0);
`endif
      tick();
    end
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
